// File: rtl/video_pkg.sv
// Shared video definitions for the sync-cleaning path.
//   rgb888_t  : packed {r, g, b} pixel, COLOR_W bits per channel
//   COLOR_W   : bits per colour channel
//   POL_CNT_W : default width of the sync-polarity measurement counters
package video_pkg;

   localparam int COLOR_W   = 8;
   localparam int POL_CNT_W = 12;

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } rgb888_t;

endpackage

// File: rtl/sync_polarity_det.sv
// Sync polarity detector.
// Counts enabled samples while sig_in is high and while it is low (both
// counters saturate). On each raw rising edge of sig_in the polarity is
// decided (pol = 1 when the signal was mostly high, i.e. active-low) and
// the counters restart.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   ce         : sample enable; nothing advances while low
//   sig_in     : raw sync input, either polarity
//   cnt_en     : qualifies which ce samples are counted
//   pol        : 1 = sig_in is active-low
module sync_polarity_det
   import video_pkg::*;
#(
   parameter int CNT_W = POL_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic ce,
   input  logic sig_in,
   input  logic cnt_en,
   output logic pol
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             sig_prev_q, sig_prev_d;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] lo_q, lo_d;
   logic             pol_q, pol_d;
   logic             rise;

   always_comb begin
      sig_prev_d = sig_prev_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      pol_d      = pol_q;
      rise       = sig_in & ~sig_prev_q;
      if (ce) begin
         sig_prev_d = sig_in;
         if (rise) begin
            // ties resolve to active-high
            pol_d = (hi_q > lo_q);
            hi_d  = '0;
            lo_d  = '0;
         end else if (cnt_en) begin
            if (sig_in) begin
               if (hi_q != CNT_MAX) hi_d = hi_q + 1'b1;
            end else begin
               if (lo_q != CNT_MAX) lo_d = lo_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_prev_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         pol_q      <= 1'b0;
      end else begin
         sig_prev_q <= sig_prev_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         pol_q      <= pol_d;
      end
   end

   assign pol = pol_q;

endmodule

// File: rtl/video_sync_cleaner.sv
// Video sync cleaner: normalises hs/vs of unknown polarity to active-high,
// quantises vsync/vblank to line starts, derives DE from the blanks and
// registers pixel data, all advancing on ce_pix.
// Optional build macro VIDEO_SYNC_CLEANER_BLANK_EN: when defined, dout is
// forced to black whenever the next de_out is 0; otherwise data passes
// through unchanged during blanking.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   ce_pix           : pixel enable
//   din              : {R,G,B} pixel in
//   hs_in, vs_in     : raw syncs, either polarity
//   hblank, vblank   : active-high blanks
//   dout             : registered pixel data
//   hs_out, vs_out   : active-high syncs (vs_out line-aligned)
//   de_out           : ~(hblank | line-aligned vblank)
//   ce_out           : ce_pix delayed one clk
module video_sync_cleaner
   import video_pkg::*;
#(
   parameter int CNT_W = POL_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_pix,
   input  logic [23:0] din,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        hblank,
   input  logic        vblank,
   output logic [23:0] dout,
   output logic        hs_out,
   output logic        vs_out,
   output logic        de_out,
   output logic        ce_out
);

   logic    pol_h, pol_v;
   logic    hs_n, vs_n, hs_n_rise;
   logic    hs_n_prev_q, hs_n_prev_d;
   logic    vbl_l_q, vbl_l_d;
   logic    vs_out_q, vs_out_d;
   logic    hs_out_q, hs_out_d;
   logic    de_out_q, de_out_d;
   logic    ce_out_q, ce_out_d;
   rgb888_t dout_q, dout_d;

   // polarity registers are used as-is this cycle; a freshly decided
   // polarity only takes effect on the following ce_pix sample
   assign hs_n      = hs_in ^ pol_h;
   assign vs_n      = vs_in ^ pol_v;
   assign hs_n_rise = ce_pix & hs_n & ~hs_n_prev_q;

   sync_polarity_det #(.CNT_W(CNT_W)) u_hdet (
      .clk    (clk),
      .reset  (reset),
      .ce     (ce_pix),
      .sig_in (hs_in),
      .cnt_en (1'b1),
      .pol    (pol_h)
   );

   // vertical detector counts lines, not pixels
   sync_polarity_det #(.CNT_W(CNT_W)) u_vdet (
      .clk    (clk),
      .reset  (reset),
      .ce     (ce_pix),
      .sig_in (vs_in),
      .cnt_en (hs_n_rise),
      .pol    (pol_v)
   );

   always_comb begin
      hs_n_prev_d = hs_n_prev_q;
      vbl_l_d     = vbl_l_q;
      vs_out_d    = vs_out_q;
      hs_out_d    = hs_out_q;
      de_out_d    = de_out_q;
      dout_d      = dout_q;
      ce_out_d    = ce_pix;
      if (ce_pix) begin
         hs_n_prev_d = hs_n;
         hs_out_d    = hs_n;
         de_out_d    = ~(hblank | vbl_l_q);
`ifdef VIDEO_SYNC_CLEANER_BLANK_EN
         dout_d      = de_out_d ? din : '0;
`else
         dout_d      = din;
`endif
         if (hs_n_rise) begin
            vs_out_d = vs_n;
            vbl_l_d  = vblank;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_n_prev_q <= 1'b0;
         vbl_l_q     <= 1'b1;
         vs_out_q    <= 1'b0;
         hs_out_q    <= 1'b0;
         de_out_q    <= 1'b0;
         ce_out_q    <= 1'b0;
         dout_q      <= '0;
      end else begin
         hs_n_prev_q <= hs_n_prev_d;
         vbl_l_q     <= vbl_l_d;
         vs_out_q    <= vs_out_d;
         hs_out_q    <= hs_out_d;
         de_out_q    <= de_out_d;
         ce_out_q    <= ce_out_d;
         dout_q      <= dout_d;
      end
   end

   assign dout   = dout_q;
   assign hs_out = hs_out_q;
   assign vs_out = vs_out_q;
   assign de_out = de_out_q;
   assign ce_out = ce_out_q;

endmodule

// File: tb/tb_video_sync_cleaner.sv
module tb_video_sync_cleaner;

   localparam int CNT_W  = 4;   // small so saturation is exercised every line
   localparam int LINE   = 80;
   localparam int HS_LEN = 10;
   localparam int HB_LEN = 16;
   localparam int NLINES = 20;
   localparam int VS_LINE = 3;
   localparam int VB_LINE = 15;
   localparam int MID    = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce_pix;
   logic [23:0] din;
   logic        hs_in, vs_in, hblank, vblank;
   logic [23:0] dout;
   logic        hs_out, vs_out, de_out, ce_out;

   always #5 clk = ~clk;

   video_sync_cleaner #(.CNT_W(CNT_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .ce_pix (ce_pix),
      .din    (din),
      .hs_in  (hs_in),
      .vs_in  (vs_in),
      .hblank (hblank),
      .vblank (vblank),
      .dout   (dout),
      .hs_out (hs_out),
      .vs_out (vs_out),
      .de_out (de_out),
      .ce_out (ce_out)
   );

   typedef struct packed {
      logic        e_ce;
      logic        e_hs;
      logic        e_vs;
      logic        e_de;
      logic [23:0] e_dout;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;
   int   vectors = 0;
   int   errors  = 0;
   bit   hs_low;
   bit   vs_low;
   int   vs_pix;
   int   ce_div;

   // steady-state expectation for the sample taken at pixel (l,p)
   function automatic exp_t expect_pix(int l, int p, logic [23:0] d);
      exp_t e;
      e.e_ce   = 1'b1;
      e.e_hs   = (p < HS_LEN);
      e.e_vs   = (l == VS_LINE + 1) || (l == VS_LINE + 2);
      e.e_de   = (p >= HB_LEN) && (l >= 1) && (l <= VB_LINE);
`ifdef VIDEO_SYNC_CLEANER_BLANK_EN
      e.e_dout = e.e_de ? d : 24'h000000;
`else
      e.e_dout = d;
`endif
      return e;
   endfunction

   task automatic drive_inputs(int l, int p);
      logic vs_act;
      hs_in  = (p < HS_LEN) ^ hs_low;
      vs_act = (l == VS_LINE && p >= vs_pix) || (l == VS_LINE + 1) ||
               (l == VS_LINE + 2 && p < vs_pix);
      vs_in  = vs_act ^ vs_low;
      hblank = (p < HB_LEN);
      vblank = (l > VB_LINE) || (l == VB_LINE && p >= MID) || (l == 0 && p < MID);
      din    = (hblank | vblank) ? 24'hFF8040 : {8'(l), 8'(p), 8'hA5};
   endtask

   task automatic pixel(int l, int p, bit chk);
      exp_t e, got;
      drive_inputs(l, p);
      for (int k = 0; k < ce_div; k++) begin
         ce_pix = (k == 0);
         if (ce_pix) begin
            e = expect_pix(l, p, din);
         end else begin
            e      = last_exp;
            e.e_ce = 1'b0;
         end
         sb_q.push_back(e);
         @(posedge clk);
         #1;
         e   = sb_q.pop_front();
         got = {ce_out, hs_out, vs_out, de_out, dout};
         if (ce_pix) last_exp = e;
         vectors++;
         if (chk) begin
            if (got !== e) begin
               errors++;
               $display("FAIL outputs l=%0d p=%0d k=%0d got ce=%b hs=%b vs=%b de=%b dout=%h exp ce=%b hs=%b vs=%b de=%b dout=%h",
                        l, p, k, got.e_ce, got.e_hs, got.e_vs, got.e_de, got.e_dout,
                        e.e_ce, e.e_hs, e.e_vs, e.e_de, e.e_dout);
            end
         end else if (ce_out !== e.e_ce) begin
            errors++;
            $display("FAIL ce_out l=%0d p=%0d k=%0d got %b exp %b", l, p, k, ce_out, e.e_ce);
         end
      end
   endtask

   task automatic run_lines(int l0, int l1, bit chk);
      for (int l = l0; l < l1; l++)
         for (int p = 0; p < LINE; p++)
            pixel(l, p, chk);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      ce_pix = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_zero(string tag);
      vectors++;
      if ({dout, hs_out, vs_out, de_out, ce_out} !== 28'h0) begin
         errors++;
         $display("FAIL %s got dout=%h hs=%b vs=%b de=%b ce=%b exp all zero",
                  tag, dout, hs_out, vs_out, de_out, ce_out);
      end
   endtask

   task automatic test_reset();
      hs_low = 1'b0; vs_low = 1'b0; vs_pix = MID; ce_div = 1;
      drive_inputs(1, 50);
      ce_pix = 1'b1;
      reset  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_values");
      reset = 1'b0;
   endtask

   // active-low hs, active-high vs toggled mid-line
   task automatic test_h_polarity();
      hs_low = 1'b1; vs_low = 1'b0; vs_pix = MID; ce_div = 1;
      do_reset();
      run_lines(0, NLINES, 1'b0);
      run_lines(0, NLINES, 1'b1);
      run_lines(0, NLINES, 1'b1);
   endtask

   // active-low vs whose raw rise coincides with the raw hs rise
   task automatic test_v_polarity();
      hs_low = 1'b1; vs_low = 1'b1; vs_pix = HS_LEN; ce_div = 1;
      do_reset();
      run_lines(0, NLINES, 1'b0);
      run_lines(0, NLINES, 1'b1);
      run_lines(0, NLINES, 1'b1);
   endtask

   task automatic test_ce_div();
      hs_low = 1'b0; vs_low = 1'b0; vs_pix = MID; ce_div = 4;
      do_reset();
      run_lines(0, NLINES, 1'b0);
      run_lines(0, NLINES, 1'b1);
      ce_div = 1;
   endtask

   task automatic test_reset_midframe();
      hs_low = 1'b1; vs_low = 1'b1; vs_pix = MID; ce_div = 1;
      do_reset();
      run_lines(0, NLINES, 1'b0);
      run_lines(0, 10, 1'b1);
      ce_pix = 1'b1;
      reset  = 1'b1;
      #1;
      check_zero("reset_async");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_zero("reset_hold");
      end
      reset = 1'b0;
      run_lines(10, NLINES, 1'b0);
      run_lines(0, NLINES, 1'b0);
      run_lines(0, NLINES, 1'b1);
   endtask

   initial begin
      reset  = 1'b1;
      ce_pix = 1'b0;
      hs_in  = 1'b0; vs_in = 1'b0; hblank = 1'b0; vblank = 1'b0; din = '0;
      hs_low = 1'b0; vs_low = 1'b0; vs_pix = MID; ce_div = 1;
      last_exp = '0;
      test_reset();
      test_h_polarity();
      test_v_polarity();
      test_ce_div();
      test_reset_midframe();
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d left exp 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
